// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 UART receiver feeding a NUM_BYTES command assembler,
// with framing-error rejection and overrun detection.
// Optional inter-byte timeout is built only when CMD_TIMEOUT_EN is defined.
module uart_cmd_rcv #(
    parameter int BAUD_DIV  = 2604,
    parameter int NUM_BYTES = 2,
    parameter int MSB_FIRST = 0,
    parameter int TO_BITS   = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   RX,
    input  logic                   clr_cmd_rdy,
    output logic                   cmd_rdy,
    output logic [NUM_BYTES*8-1:0] cmd,
    output logic                   frm_err,
    output logic                   ovr
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int CW = $clog2(NUM_BYTES) + 1;
    localparam int W  = NUM_BYTES * 8;

    localparam logic [TW-1:0] FULL_T = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] HALF_T = TW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST_B = CW'(NUM_BYTES - 1);

    if (BAUD_DIV < 4 || NUM_BYTES < 1 || NUM_BYTES > 8 || TO_BITS < 1) begin : g_bad_params
        $error("uart_cmd_rcv: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_s;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [CW-1:0]   byte_cnt;
    logic [W-1:0]    hold;
    logic [W-1:0]    word;
    int              slot;
    logic            timer_clr, shift_en, byte_good, byte_bad, last_byte, timeout;

    // Double-flop synchroniser for the asynchronous RX pin (idles high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Receiver next-state and per-clock strobes
    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        shift_en  = 1'b0;
        byte_good = 1'b0;
        byte_bad  = 1'b0;
        unique case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (timer == HALF_T) begin
                    timer_clr = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL_T) begin
                    timer_clr = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (timer == FULL_T) begin
                    timer_clr = 1'b1;
                    if (rx_s) begin
                        byte_good = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        byte_bad  = 1'b1;
                        state_nxt = BRK;
                    end
                end
            end
            BRK: begin
                timer_clr = 1'b1;
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timer, bit counter and LSB-first data shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            timer <= timer_clr ? '0 : timer + TW'(1);
            if (state == IDLE)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

    // Place the received byte into its slot of the hold word
    always_comb begin
        slot      = (MSB_FIRST != 0) ? (NUM_BYTES - 1 - int'(byte_cnt)) : int'(byte_cnt);
        word      = hold;
        word[slot*8 +: 8] = shreg;
        last_byte = (byte_cnt == LAST_B);
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TO_CLKS = TO_BITS * BAUD_DIV;
    localparam int IW      = $clog2(TO_CLKS + 1);

    logic [IW-1:0] idle_cnt;

    assign timeout = (state == IDLE) && rx_s && (byte_cnt != '0) &&
                     (idle_cnt == IW'(TO_CLKS - 1));

    // Inter-byte idle counter; restarts whenever a frame begins or no partial command exists
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          idle_cnt <= '0;
        else if (state != IDLE || !rx_s || byte_cnt == '0 || timeout) idle_cnt <= '0;
        else                                                 idle_cnt <= idle_cnt + IW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // Command assembly, cmd_rdy handshake, overrun and framing-error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            hold     <= '0;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
            ovr      <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            frm_err <= byte_bad;
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
                ovr     <= 1'b0;
            end
            if (byte_bad || timeout) begin
                byte_cnt <= '0;
            end else if (byte_good) begin
                if (last_byte) begin
                    byte_cnt <= '0;
                    // a completion on the acknowledge clock is accepted, not an overrun
                    if (cmd_rdy && !clr_cmd_rdy) begin
                        ovr <= 1'b1;
                    end else begin
                        cmd     <= word;
                        cmd_rdy <= 1'b1;
                    end
                end else begin
                    hold     <= word;
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Scoreboard bench for uart_cmd_rcv: BAUD_DIV=16 with 2-byte LSB-first,
// 2-byte MSB-first and 3-byte instances, each fed from its own gated RX line.
module tb_uart_cmd_rcv;

    localparam int BD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;
    logic [1:0] sel = 2'd0;
    logic clr_a = 1'b0, clr_m = 1'b0, clr_3 = 1'b0;

    logic rx_a, rx_m, rx_3;
    logic rdy_a, rdy_m, rdy_3;
    logic [15:0] cmd_a, cmd_m;
    logic [23:0] cmd_3;
    logic frm_a, frm_m, frm_3;
    logic ovr_a, ovr_m, ovr_3;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int frame_cyc = 0;
    int last_lat = 0;
    int frm_cnt = 0;
    int frm_long = 0;

    logic [63:0] q_a[$], q_m[$], q_3[$];

    assign rx_a = (sel == 2'd0) ? rx_line : 1'b1;
    assign rx_m = (sel == 2'd1) ? rx_line : 1'b1;
    assign rx_3 = (sel == 2'd2) ? rx_line : 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_rcv #(.BAUD_DIV(BD), .NUM_BYTES(2), .MSB_FIRST(0), .TO_BITS(20)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx_a), .clr_cmd_rdy(clr_a),
        .cmd_rdy(rdy_a), .cmd(cmd_a), .frm_err(frm_a), .ovr(ovr_a));

    uart_cmd_rcv #(.BAUD_DIV(BD), .NUM_BYTES(2), .MSB_FIRST(1), .TO_BITS(20)) dut_m (
        .clk(clk), .rst_n(rst_n), .RX(rx_m), .clr_cmd_rdy(clr_m),
        .cmd_rdy(rdy_m), .cmd(cmd_m), .frm_err(frm_m), .ovr(ovr_m));

    uart_cmd_rcv #(.BAUD_DIV(BD), .NUM_BYTES(3), .MSB_FIRST(0), .TO_BITS(20)) dut_3 (
        .clk(clk), .rst_n(rst_n), .RX(rx_3), .clr_cmd_rdy(clr_3),
        .cmd_rdy(rdy_3), .cmd(cmd_3), .frm_err(frm_3), .ovr(ovr_3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One 8N1 frame driven clock by clock; clr_at>0 raises clr_a for exactly the
    // clock ending clr_at clocks after the start-bit edge.
    task automatic send_byte(input logic [7:0] d, input bit stop, input int clr_at);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int k = 0; k < 10 * BD; k++) begin
            @(posedge clk); #1;
            if (k == 0) frame_cyc = cyc;
            rx_line = fr[k / BD];
            if (clr_at > 0) clr_a = (k == clr_at - 1);
        end
        @(posedge clk); #1;
        rx_line = 1'b1;
        clr_a = 1'b0;
        repeat (2 * BD) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr_a();
        @(posedge clk); #1 clr_a = 1'b1;
        @(posedge clk); #1 clr_a = 1'b0;
        chk("clr_drops_cmd_rdy", {63'd0, rdy_a}, 64'd0);
        chk("clr_drops_ovr", {63'd0, ovr_a}, 64'd0);
    endtask

    // Main-instance monitor: pops on each newly presented command and checks latency
    logic       prev_rdy_a = 1'b0;
    logic [15:0] prev_cmd_a = '0;
    logic       prev_frm_a = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (frm_a && !prev_frm_a) frm_cnt++;
            if (frm_a && prev_frm_a)  frm_long++;
            if (rdy_a && (!prev_rdy_a || cmd_a != prev_cmd_a)) begin
                if (q_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_cmd_a: got 0x%0h, expected no command", cmd_a);
                end else begin
                    chk("cmd_a", {48'd0, cmd_a}, q_a.pop_front());
                    last_lat = cyc - frame_cyc;
                    tests++;
                    if (last_lat < 9 * BD + BD / 2 - 2 || last_lat > 10 * BD) begin
                        fails++;
                        $display("FAIL cmd_rdy_latency: got %0d clocks after last start bit, expected within stop bit", last_lat);
                    end
                end
            end
        end
        prev_rdy_a = rdy_a;
        prev_cmd_a = cmd_a;
        prev_frm_a = frm_a;
    end

    // Secondary monitors: pop on cmd_rdy rising
    logic prev_rdy_m = 1'b0, prev_rdy_3 = 1'b0;
    always @(negedge clk) begin
        if (rst_n && rdy_m && !prev_rdy_m) begin
            if (q_m.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_cmd_m: got 0x%0h, expected no command", cmd_m);
            end else chk("cmd_msb_first", {48'd0, cmd_m}, q_m.pop_front());
        end
        if (rst_n && rdy_3 && !prev_rdy_3) begin
            if (q_3.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_cmd_3: got 0x%0h, expected no command", cmd_3);
            end else chk("cmd_3byte", {40'd0, cmd_3}, q_3.pop_front());
        end
        prev_rdy_m = rdy_m;
        prev_rdy_3 = rdy_3;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_rdy", {63'd0, rdy_a}, 64'd0);
        chk("reset_cmd", {48'd0, cmd_a}, 64'd0);
        chk("reset_ovr", {63'd0, ovr_a}, 64'd0);
        chk("reset_frm_err", {63'd0, frm_a}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;

        // 1: LSB-first 2-byte command, then acknowledge
        q_a.push_back(64'h1234);
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        chk("t1_cmd_rdy_held", {63'd0, rdy_a}, 64'd1);
        pulse_clr_a();

        // 2: MSB-first and 3-byte instances
        sel = 2'd1;
        q_m.push_back(64'h3412);
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        sel = 2'd2;
        q_3.push_back(64'h030201);
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h02, 1'b1, 0);
        send_byte(8'h03, 1'b1, 0);
        sel = 2'd0;

        // 3: framing error dropped, then a good command
        send_byte(8'hAA, 1'b0, 0);
        chk("t3_frm_err_pulses", frm_cnt, 1);
        chk("t3_no_rdy_after_bad", {63'd0, rdy_a}, 64'd0);
        q_a.push_back(64'h1234);
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        pulse_clr_a();

        // 4: overrun, then acknowledge coinciding with a completion
        q_a.push_back(64'h1234);
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h78, 1'b1, 0);
        send_byte(8'h56, 1'b1, 0);
        chk("t4_ovr_set", {63'd0, ovr_a}, 64'd1);
        chk("t4_cmd_kept", {48'd0, cmd_a}, 64'h1234);
        chk("t4_rdy_kept", {63'd0, rdy_a}, 64'd1);
        lat = (last_lat >= 9 * BD && last_lat <= 10 * BD) ? last_lat : 155;
        q_a.push_back(64'h9ABC);
        send_byte(8'hBC, 1'b1, 0);
        send_byte(8'h9A, 1'b1, lat);
        chk("t4_same_clk_cmd", {48'd0, cmd_a}, 64'h9ABC);
        chk("t4_same_clk_rdy", {63'd0, rdy_a}, 64'd1);
        chk("t4_same_clk_ovr", {63'd0, ovr_a}, 64'd0);
        pulse_clr_a();

        // 5: short low glitch between the two bytes of a command
        q_a.push_back(64'h1234);
        send_byte(8'h34, 1'b1, 0);
        @(posedge clk); #1 rx_line = 1'b0;
        repeat (6) @(posedge clk);
        #1 rx_line = 1'b1;
        repeat (3 * BD) @(posedge clk); #1;
        send_byte(8'h12, 1'b1, 0);
        chk("t5_glitch_no_frm_err", frm_cnt, 1);

        // 5: reset in the middle of the second byte's data bits
        send_byte(8'h34, 1'b1, 0);
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'h12, 1'b0};
            for (int k = 0; k < 5 * BD; k++) begin
                @(posedge clk); #1 rx_line = fr[k / BD];
            end
        end
        rst_n = 1'b0;
        rx_line = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_rst_cmd_rdy", {63'd0, rdy_a}, 64'd0);
        chk("t5_rst_cmd", {48'd0, cmd_a}, 64'd0);
        chk("t5_rst_ovr", {63'd0, ovr_a}, 64'd0);
        chk("t5_rst_frm_err", {63'd0, frm_a}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2 * BD) @(posedge clk); #1;
        q_a.push_back(64'h1234);
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        pulse_clr_a();

        // 6: long idle after a lone byte
`ifdef CMD_TIMEOUT_EN
        q_a.push_back(64'h1234);
`else
        q_a.push_back(64'h3455);
`endif
        send_byte(8'h55, 1'b1, 0);
        repeat (19 * BD) @(posedge clk); #1;
        send_byte(8'h34, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);

        repeat (4 * BD) @(posedge clk); #1;
        chk("q_a_drained", q_a.size(), 0);
        chk("q_m_drained", q_m.size(), 0);
        chk("q_3_drained", q_3.size(), 0);
        chk("frm_err_single_clock", frm_long, 0);
        chk("frm_err_total", frm_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rcv.md
Name: uart_cmd_rcv

Overview:
- Parametrised successor to the two-byte UART command wrapper.
- Integrates an 8N1 UART receiver with a command assembler that collects NUM_BYTES bytes into one command word, with selectable byte order.
- Adds framing-error rejection, overrun detection and an optional inter-byte timeout.
- Sits between the RX pin and the command processor, which consumes cmd while cmd_rdy is high and then pulses clr_cmd_rdy.

Parameters:
- BAUD_DIV, 2604, clocks per bit period (50 MHz / 19200 baud); must be ≥ 4.
- NUM_BYTES, 2, bytes per command; legal range 1..8.
- MSB_FIRST, 0, 0: first byte received lands in cmd[7:0]; 1: first byte received lands in the top byte.
- TO_BITS, 20, inter-byte timeout in bit periods; used only when CMD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial input, idles high, asynchronous to clk
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy
- cmd_rdy  out  1  a complete command is held on cmd
- cmd  out  NUM_BYTES*8  assembled command
- frm_err  out  1  one-clock pulse when a byte's stop bit samples 0
- ovr  out  1  sticky; a command completed while cmd_rdy was high

Behaviour:
- Reset (asynchronous, rst_n low):
  - cmd_rdy=0, cmd=0, frm_err=0, ovr=0.
  - Byte counter=0, receiver in IDLE, RX synchroniser preset to 1.
  - Reset mid-frame discards the partial byte and any partial command.
- RX input: double-flop synchronised before any use.
- Receiver FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: waits for synchronised RX=0.
  - START: re-samples RX at BAUD_DIV/2. If RX=1 (glitch), returns to IDLE with no output.
  - DATA: samples 8 bits LSB-first at mid-bit, BAUD_DIV clocks apart.
  - STOP: samples the stop bit at mid-bit. Stop=1 completes the byte; stop=0 pulses frm_err for one clock, drops the byte, clears the byte counter (partial command discarded), and the FSM waits for RX=1 before returning to IDLE.
- Assembler:
  - Each good byte is written into byte slot byte_cnt, or slot NUM_BYTES-1-byte_cnt when MSB_FIRST=1, of an internal shift/hold register; byte_cnt then increments.
  - When the last byte arrives, byte_cnt wraps to 0 and the full word is transferred to cmd.
  - cmd_rdy rises on the clock after the stop-bit sample of the last byte.
  - cmd is stable while cmd_rdy=1.
- cmd_rdy handshake:
  - Set on completion, cleared by clr_cmd_rdy.
  - If clr_cmd_rdy and a completion occur in the same clock: completion wins. cmd updates, cmd_rdy stays 1, ovr is not set.
  - Reception continues while cmd_rdy=1; bytes of the next command accumulate normally.
- Overrun:
  - A completion while cmd_rdy=1 and clr_cmd_rdy=0 sets ovr. The new command is discarded and cmd keeps the old value.
  - ovr clears only on the clr_cmd_rdy pulse.
- NUM_BYTES=1: every good byte is a complete command; the hold register is unused.
- Counter widths: bit-timer $clog2(BAUD_DIV) bits; byte counter $clog2(NUM_BYTES)+1 bits. No wrap beyond NUM_BYTES-1.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - An idle counter runs while byte_cnt≠0 and the receiver is in IDLE.
  - It restarts at each start-bit detect.
  - When it reaches TO_BITS*BAUD_DIV clocks, byte_cnt returns to 0 and the partial command is discarded silently; no flag is raised.
  - This resynchronises command framing after a lost byte.
- Not defined:
  - No timeout logic is built.
  - A partial command waits indefinitely for its remaining bytes.

Test Plan (BAUD_DIV=16, NUM_BYTES=2 unless noted):
1. Bytes 0x34 then 0x12, MSB_FIRST=0 -> cmd=0x1234, cmd_rdy=1 exactly 1 clock after the stop-bit mid-sample of the second byte; clr_cmd_rdy pulse -> cmd_rdy=0 next clock.
2. Same bytes with MSB_FIRST=1 -> cmd=0x3412. With NUM_BYTES=3 and bytes 0x01,0x02,0x03 at MSB_FIRST=0 -> cmd=0x030201.
3. Byte 0xAA sent with stop bit=0, then 0x34, 0x12 -> frm_err single pulse, no cmd_rdy after the bad byte, then cmd=0x1234.
4. Two commands 0x1234 and 0x5678 with no clr_cmd_rdy -> cmd stays 0x1234 and ovr=1. Next, clr_cmd_rdy asserted on the same clock as a third completion (0x9ABC) -> cmd=0x9ABC, cmd_rdy=1, ovr=0.
5. 6-clock low glitch on RX -> no byte received, no frm_err, byte_cnt unchanged. rst_n pulsed mid-DATA of the second byte -> all outputs 0; next full pair 0x34,0x12 gives cmd=0x1234.
6. CMD_TIMEOUT_EN defined, TO_BITS=20: send 0x55, idle 21 bit periods, then 0x34, 0x12 -> cmd=0x1234. Without the macro, the same stimulus -> cmd=0x3455.
